// File: rtl/bk_kbd_pkg.sv
// +--------------------------------------------------------------------------+
// | bk_kbd_pkg : register map, STATE bit positions and default vectors for   |
// |              the keyboard register block.                                |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

package bk_kbd_pkg;

   localparam logic [15:0] STATE_OFS = 16'o0;
   localparam logic [15:0] DATA_OFS  = 16'o2;

   localparam int INT_DIS_BIT = 6;
   localparam int RDY_BIT     = 7;
   localparam int OVR_BIT     = 15;

   localparam logic [15:0] VEC_NORMAL_DFLT = 16'o060;
   localparam logic [15:0] VEC_AR2_DFLT    = 16'o274;

   localparam int KEY_W = 9;

endpackage

`default_nettype wire

// File: rtl/bk_sync_fifo.sv
// +--------------------------------------------------------------------------+
// | bk_sync_fifo : single-clock FIFO with show-ahead head output; a pop on   |
// |                the same cycle as a push frees room for it when full.     |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
`default_nettype none

module bk_sync_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign head    = mem_q[rd_ptr_q];
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; validity is tracked by count_q alone.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

`default_nettype wire

// File: rtl/bk_kbd_regs.sv
// +--------------------------------------------------------------------------+
// | bk_kbd_regs : keyboard STATE/DATA registers, key FIFO and interrupt      |
// |               request. Define BK_KBD_OVERRUN_EN for the sticky overrun.  |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
`default_nettype none

module bk_kbd_regs
   import bk_kbd_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR  = 16'o177660,
   parameter int          DEPTH      = 8,
   parameter logic [15:0] VEC_NORMAL = VEC_NORMAL_DFLT,
   parameter logic [15:0] VEC_AR2    = VEC_AR2_DFLT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ce,
   input  logic [15:0] adr,
   input  logic        din,
   input  logic        dout,
   input  logic        wtbt,
   input  logic [15:0] data_i,
   output logic [15:0] data_o,
   output logic        rply,
   output logic        hit,
   input  logic        key_valid,
   input  logic [7:0]  key_code,
   input  logic        key_ar2,
   output logic        key_ready,
   input  logic        pri_ok,
   input  logic        iako,
   output logic        virq,
   output logic [15:0] vector
);

   localparam logic [15:0] STATE_ADR = BASE_ADDR + STATE_OFS;
   localparam logic [15:0] DATA_ADR  = BASE_ADDR + DATA_OFS;

   logic              rply_q, rply_d;
   logic [15:0]       rdata_q, rdata_d;
   logic              int_dis_q, int_dis_d;
   logic              iako_q, iako_d;
   logic [15:0]       vector_q, vector_d;
   logic              ovr;

   logic              state_sel, data_sel, bus_req, rise;
   logic              rd_pop, st_wr, st_rd, dropped;
   logic              fifo_push, fifo_full, fifo_empty;
   logic [KEY_W-1:0]  fifo_head;
   logic [15:0]       state_word, data_word, live_word, sel_word;
   logic              unused_data_bits;

   assign state_sel = (adr[15:1] == STATE_ADR[15:1]);
   assign data_sel  = (adr[15:1] == DATA_ADR[15:1]);
   assign hit       = state_sel | data_sel;
   assign bus_req   = din | dout;
   assign rise      = ce & ~rply_q & bus_req & hit;
   assign rd_pop    = rise & din & data_sel;
   assign st_rd     = rise & din & state_sel;
   assign st_wr     = rise & dout & state_sel & (~wtbt | ~adr[0]);
   assign fifo_push = ce & key_valid;
   assign dropped   = fifo_push & fifo_full & ~rd_pop;

   assign unused_data_bits = ^{data_i[15:INT_DIS_BIT+1], data_i[INT_DIS_BIT-1:0]};

   bk_sync_fifo #(
      .WIDTH (KEY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .pop   (rd_pop),
      .wdata ({key_ar2, key_code}),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (fifo_head)
   );

`ifdef BK_KBD_OVERRUN_EN
   logic ovr_q, ovr_d;

   always_comb begin
      ovr_d = ovr_q;
      if (st_rd)   ovr_d = 1'b0;
      if (dropped) ovr_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) ovr_q <= 1'b0;
      else       ovr_q <= ovr_d;
   end

   assign ovr = ovr_q;
`else
   logic unused_ovr_inputs;
   assign unused_ovr_inputs = dropped ^ st_rd;
   assign ovr = 1'b0;
`endif

   always_comb begin
      state_word              = '0;
      state_word[OVR_BIT]     = ovr;
      state_word[RDY_BIT]     = ~fifo_empty;
      state_word[INT_DIS_BIT] = int_dis_q;
   end

   assign data_word = fifo_empty ? 16'o0 : {8'h00, fifo_head[7:0]};
   assign live_word = data_sel ? data_word : state_word;
   // While rply is up the CPU sees the value captured before the pop took effect.
   assign sel_word  = rply_q ? rdata_q : live_word;
   assign data_o    = ~hit ? 16'o177777 :
                      (wtbt & adr[0]) ? {8'h00, sel_word[15:8]} : sel_word;

   always_comb begin
      rply_d    = rply_q;
      rdata_d   = rdata_q;
      int_dis_d = int_dis_q;
      iako_d    = iako_q;
      vector_d  = vector_q;
      if (ce) begin
         rply_d = rply_q ? bus_req : (bus_req & hit);
         iako_d = iako;
         if (iako & ~iako_q)
            vector_d = (fifo_head[8] & ~fifo_empty) ? VEC_AR2 : VEC_NORMAL;
      end
      if (rise)  rdata_d   = live_word;
      if (st_wr) int_dis_d = data_i[INT_DIS_BIT];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rply_q    <= 1'b0;
         rdata_q   <= '0;
         int_dis_q <= 1'b0;
         iako_q    <= 1'b0;
         vector_q  <= VEC_NORMAL;
      end else begin
         rply_q    <= rply_d;
         rdata_q   <= rdata_d;
         int_dis_q <= int_dis_d;
         iako_q    <= iako_d;
         vector_q  <= vector_d;
      end
   end

   assign rply      = rply_q;
   assign key_ready = ~fifo_full;
   assign virq      = ~fifo_empty & ~int_dis_q & pri_ok;
   assign vector    = vector_q;

endmodule

`default_nettype wire
